octave_select: RTL and testbench

Parametrised octave selector for the synth front end: turns the synchronised octave-up/octave-down button levels into a registered octave index that the note/divider logic uses to shift pitch. Supersedes the fixed 4-state down-only octave FSM with:
- a configurable octave count,
- up and down stepping,
- a saturate or wrap mode,
- a programmable reset octave,
- optional press-and-hold auto-repeat.

---
 rtl/octave_select.sv | 162 ++++++++++++++++
 tb/tb_octave_select.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octave_select.sv
`default_nettype none
// ============================================================================
//  Module      : octave_select
//  Description : Octave selector for the synth front end. Converts the
//                synchronised octave-up / octave-down button levels into a
//                registered octave index. Supports saturating or wrapping
//                limits, a programmable reset octave, and optional
//                press-and-hold auto-repeat.
//
//  Ports
//    clk         in   1      system clock, rising edge
//    rst         in   1      synchronous active-high reset
//    oct_up      in   1      octave-up level (index - 1)
//    oct_down    in   1      octave-down level (index + 1)
//    oct_switch  out  OCT_W  current octave index, 0 = highest pitch
//    oct_changed out  1      one-cycle pulse when oct_switch changes
//    limit_hit   out  1      one-cycle pulse on a step refused at a limit
//    at_min      out  1      oct_switch == 0 (combinational)
//    at_max      out  1      oct_switch == NUM_OCT-1 (combinational)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module octave_select #(
    parameter int NUM_OCT       = 4,
    parameter int OCT_W         = $clog2(NUM_OCT),
    parameter int DEFAULT_OCT   = 0,
    parameter int WRAP          = 0,
    parameter int REPEAT_EN     = 0,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oct_up,
    input  logic             oct_down,
    output logic [OCT_W-1:0] oct_switch,
    output logic             oct_changed,
    output logic             limit_hit,
    output logic             at_min,
    output logic             at_max
);

    localparam int c_tmr_max = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_tmr_w-1:0] c_hold_ld = c_tmr_w'(HOLD_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_rep_ld  = c_tmr_w'(REPEAT_CYCLES - 1);
    localparam logic [OCT_W-1:0]   c_last    = OCT_W'(NUM_OCT - 1);
    localparam logic [OCT_W-1:0]   c_default = OCT_W'(DEFAULT_OCT);
    localparam logic               c_wrap    = (WRAP != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD_DN = 2'd1,
        S_HOLD_UP = 2'd2,
        S_BOTH    = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_tmr_w-1:0] r_tmr;
    logic [OCT_W-1:0]   r_idx;
    logic               r_up_q;
    logic               r_down_q;
    logic               r_changed;
    logic               r_limit;

    logic               w_up_rise;
    logic               w_dn_rise;
    logic [OCT_W-1:0]   w_dn_idx;
    logic               w_dn_lim;
    logic [OCT_W-1:0]   w_up_idx;
    logic               w_up_lim;
    logic [OCT_W-1:0]   w_rep_idx;
    logic               w_rep_lim;

    assign w_up_rise = oct_up & ~r_up_q;
    assign w_dn_rise = oct_down & ~r_down_q;

    // Outcome of a down step and of an up step from the current index.
    // A refused step (saturating mode at a limit) leaves the index alone.
    always_comb begin
        w_dn_lim = 1'b0;
        w_up_lim = 1'b0;
        if (r_idx == c_last) begin
            w_dn_idx = c_wrap ? '0 : r_idx;
            w_dn_lim = ~c_wrap;
        end else begin
            w_dn_idx = r_idx + OCT_W'(1);
        end
        if (r_idx == '0) begin
            w_up_idx = c_wrap ? c_last : r_idx;
            w_up_lim = ~c_wrap;
        end else begin
            w_up_idx = r_idx - OCT_W'(1);
        end
    end

    // Repeat steps go in the direction of the button being held.
    assign w_rep_idx = (r_state == S_HOLD_DN) ? w_dn_idx : w_up_idx;
    assign w_rep_lim = (r_state == S_HOLD_DN) ? w_dn_lim : w_up_lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_idx     <= c_default;
            r_up_q    <= 1'b0;
            r_down_q  <= 1'b0;
            r_changed <= 1'b0;
            r_limit   <= 1'b0;
        end else begin
            r_up_q    <= oct_up;
            r_down_q  <= oct_down;
            r_changed <= 1'b0;
            r_limit   <= 1'b0;
            if (oct_up && oct_down) begin
                // Chords never step; the hold timer is abandoned.
                r_state <= S_BOTH;
                r_tmr   <= '0;
            end else if (r_state == S_BOTH) begin
                // The button still held after a chord has no new edge,
                // so it must be released before anything else happens.
                if (!oct_up && !oct_down) begin
                    r_state <= S_IDLE;
                end
            end else if (w_dn_rise) begin
                r_state   <= S_HOLD_DN;
                r_tmr     <= c_hold_ld;
                r_idx     <= w_dn_idx;
                r_changed <= ~w_dn_lim;
                r_limit   <= w_dn_lim;
            end else if (w_up_rise) begin
                r_state   <= S_HOLD_UP;
                r_tmr     <= c_hold_ld;
                r_idx     <= w_up_idx;
                r_changed <= ~w_up_lim;
                r_limit   <= w_up_lim;
            end else if ((r_state == S_HOLD_DN && !oct_down) ||
                         (r_state == S_HOLD_UP && !oct_up)) begin
                r_state <= S_IDLE;
                r_tmr   <= '0;
            end else if (r_state != S_IDLE && REPEAT_EN != 0) begin
                if (r_tmr == '0) begin
                    r_tmr     <= c_rep_ld;
                    r_idx     <= w_rep_idx;
                    r_changed <= ~w_rep_lim;
                    r_limit   <= w_rep_lim;
                end else begin
                    r_tmr <= r_tmr - c_tmr_w'(1);
                end
            end
        end
    end

    assign oct_switch  = r_idx;
    assign oct_changed = r_changed;
    assign limit_hit   = r_limit;
    assign at_min      = (r_idx == '0);
    assign at_max      = (r_idx == c_last);

endmodule
`default_nettype wire

// File: tb/tb_octave_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_octave_select
//  Description : Self-checking bench for octave_select. Three instances with
//                different configurations share one set of inputs:
//                  A: 4 octaves, reset 2, saturate, no repeat
//                  B: 5 octaves, reset 4, wrap, no repeat
//                  C: 8 octaves, reset 1, saturate, repeat (hold 4, rate 2)
//                A vector table and directed sequences use fixed expected
//                values; a random phase compares all instances with a
//                reference model based on press age arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_octave_select;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up  = 1'b0;
    logic dn  = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] a_sw;
    logic       a_chg, a_lim, a_min, a_max;
    logic [2:0] b_sw;
    logic       b_chg, b_lim, b_min, b_max;
    logic [2:0] c_sw;
    logic       c_chg, c_lim, c_min, c_max;

    octave_select #(.NUM_OCT(4), .DEFAULT_OCT(2), .WRAP(0), .REPEAT_EN(0)) u_a (
        .clk(clk), .rst(rst), .oct_up(up), .oct_down(dn),
        .oct_switch(a_sw), .oct_changed(a_chg), .limit_hit(a_lim),
        .at_min(a_min), .at_max(a_max));

    octave_select #(.NUM_OCT(5), .DEFAULT_OCT(4), .WRAP(1), .REPEAT_EN(0)) u_b (
        .clk(clk), .rst(rst), .oct_up(up), .oct_down(dn),
        .oct_switch(b_sw), .oct_changed(b_chg), .limit_hit(b_lim),
        .at_min(b_min), .at_max(b_max));

    octave_select #(.NUM_OCT(8), .DEFAULT_OCT(1), .WRAP(0), .REPEAT_EN(1),
                    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .oct_up(up), .oct_down(dn),
        .oct_switch(c_sw), .oct_changed(c_chg), .limit_hit(c_lim),
        .at_min(c_min), .at_max(c_max));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a press steps once, then while the same button is
    // held the n-th edge after the press steps when n == HOLD or when
    // n > HOLD and (n - HOLD) is a multiple of REPEAT.
    // ------------------------------------------------------------------
    int p_n   [3] = '{4, 5, 8};
    int p_def [3] = '{2, 4, 1};
    int p_wrap[3] = '{0, 1, 0};
    int p_rep [3] = '{0, 0, 1};
    int p_h   [3] = '{1000, 1000, 4};
    int p_r   [3] = '{250, 250, 2};

    int m_idx [3];
    int m_dir [3];
    int m_age [3];
    bit m_blk [3];
    bit m_chg [3];
    bit m_lim [3];
    bit m_pu = 1'b0;
    bit m_pd = 1'b0;

    task automatic apply_step(input int k, input int d);
        int n;
        n = m_idx[k] + d;
        if (n < 0 || n >= p_n[k]) begin
            if (p_wrap[k] != 0) begin
                m_idx[k] = (n + p_n[k]) % p_n[k];
                m_chg[k] = 1'b1;
            end else begin
                m_lim[k] = 1'b1;
            end
        end else begin
            m_idx[k] = n;
            m_chg[k] = 1'b1;
        end
    endtask

    task automatic model_edge(input int k);
        m_chg[k] = 1'b0;
        m_lim[k] = 1'b0;
        if (rst) begin
            m_idx[k] = p_def[k];
            m_dir[k] = 0;
            m_age[k] = 0;
            m_blk[k] = 1'b0;
        end else if (up && dn) begin
            m_blk[k] = 1'b1;
            m_dir[k] = 0;
        end else if (m_blk[k]) begin
            if (!up && !dn) m_blk[k] = 1'b0;
        end else if (dn && !m_pd) begin
            apply_step(k, 1);
            m_dir[k] = 1;
            m_age[k] = 0;
        end else if (up && !m_pu) begin
            apply_step(k, -1);
            m_dir[k] = -1;
            m_age[k] = 0;
        end else if ((m_dir[k] == 1 && !dn) || (m_dir[k] == -1 && !up)) begin
            m_dir[k] = 0;
        end else if (m_dir[k] != 0) begin
            m_age[k]++;
            if (p_rep[k] != 0 &&
                (m_age[k] == p_h[k] ||
                 (m_age[k] > p_h[k] && ((m_age[k] - p_h[k]) % p_r[k]) == 0)))
                apply_step(k, m_dir[k]);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_edge(k);
        m_pu = rst ? 1'b0 : up;
        m_pd = rst ? 1'b0 : dn;
    end

    task automatic check_models();
        chk("A switch",  32'(a_sw),  32'(m_idx[0]));
        chk("A changed", 32'(a_chg), 32'(m_chg[0]));
        chk("A limit",   32'(a_lim), 32'(m_lim[0]));
        chk("A at_min",  32'(a_min), 32'(m_idx[0] == 0));
        chk("A at_max",  32'(a_max), 32'(m_idx[0] == 3));
        chk("B switch",  32'(b_sw),  32'(m_idx[1]));
        chk("B changed", 32'(b_chg), 32'(m_chg[1]));
        chk("B limit",   32'(b_lim), 32'(m_lim[1]));
        chk("B at_min",  32'(b_min), 32'(m_idx[1] == 0));
        chk("B at_max",  32'(b_max), 32'(m_idx[1] == 4));
        chk("C switch",  32'(c_sw),  32'(m_idx[2]));
        chk("C changed", 32'(c_chg), 32'(m_chg[2]));
        chk("C limit",   32'(c_lim), 32'(m_lim[2]));
        chk("C at_min",  32'(c_min), 32'(m_idx[2] == 0));
        chk("C at_max",  32'(c_max), 32'(m_idx[2] == 7));
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1 time
    // unit after the rising edge.
    task automatic cyc(input logic r, input logic u, input logic d);
        @(negedge clk);
        rst = r;
        up  = u;
        dn  = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit r, u, d;
        int sw;
        bit chg, lim, mn, mx;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit u, bit d, int sw, bit chg, bit lim, bit mn, bit mx);
        vec_t v;
        v.r = r; v.u = u; v.d = d; v.sw = sw;
        v.chg = chg; v.lim = lim; v.mn = mn; v.mx = mx;
        tbl.push_back(v);
    endfunction

    int b_exp[5] = '{3, 2, 1, 0, 4};
    int c_exp[9] = '{1, 1, 1, 1, 2, 2, 3, 3, 4};
    bit ru, rd, rr;

    initial begin
        // Instance A: reset, down to the top limit, up to the bottom limit,
        // chords, and reset against a held button.
        //   r  u  d  sw chg lim min max
        add(1, 0, 0, 2, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 0, 0, 1);
        add(0, 0, 0, 3, 0, 0, 0, 1);
        add(0, 0, 1, 3, 0, 1, 0, 1);
        add(0, 0, 0, 3, 0, 0, 0, 1);
        add(0, 0, 1, 3, 0, 1, 0, 1);
        add(0, 0, 0, 3, 0, 0, 0, 1);
        add(0, 1, 0, 2, 1, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 1, 2, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 0, 0, 1);
        add(0, 0, 0, 3, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].u, tbl[i].d);
            chk($sformatf("tbl%0d switch", i),  32'(a_sw),  32'(tbl[i].sw));
            chk($sformatf("tbl%0d changed", i), 32'(a_chg), 32'(tbl[i].chg));
            chk($sformatf("tbl%0d limit", i),   32'(a_lim), 32'(tbl[i].lim));
            chk($sformatf("tbl%0d at_min", i),  32'(a_min), 32'(tbl[i].mn));
            chk($sformatf("tbl%0d at_max", i),  32'(a_max), 32'(tbl[i].mx));
        end

        // Instance B: wrap in both directions.
        cyc(1, 0, 0);
        chk("B reset", 32'(b_sw), 32'd4);
        cyc(0, 0, 1);
        chk("B wrap down", 32'(b_sw), 32'd0);
        chk("B wrap down changed", 32'(b_chg), 32'd1);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("B wrap up", 32'(b_sw), 32'd4);
        cyc(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0);
            chk($sformatf("B up press %0d", i), 32'(b_sw), 32'(b_exp[i]));
            cyc(0, 0, 0);
        end

        // Instance C: auto-repeat from index 0, oct_down held 9 edges.
        cyc(1, 0, 0);
        chk("C reset", 32'(c_sw), 32'd1);
        cyc(0, 1, 0);
        chk("C to zero", 32'(c_sw), 32'd0);
        cyc(0, 0, 0);
        for (int j = 0; j < 9; j++) begin
            cyc(0, 0, 1);
            chk($sformatf("C repeat edge k+%0d", j), 32'(c_sw), 32'(c_exp[j]));
        end
        for (int j = 0; j < 6; j++) begin
            cyc(0, 0, 0);
            chk($sformatf("C released %0d", j), 32'(c_sw), 32'd4);
        end

        // Hold oct_down, then add oct_up: the chord suppresses repeats.
        cyc(0, 0, 1);
        chk("C hold press", 32'(c_sw), 32'd5);
        cyc(0, 0, 1);
        for (int j = 0; j < 10; j++) begin
            cyc(0, 1, 1);
            chk($sformatf("C chord %0d", j), 32'(c_sw), 32'd5);
        end
        cyc(0, 0, 0);
        chk("C chord released", 32'(c_sw), 32'd5);

        // Reset in the middle of a hold, button still held afterwards.
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("C midhold press", 32'(c_sw), 32'd2);
        for (int j = 1; j <= 4; j++) begin
            cyc(0, 0, 1);
            chk($sformatf("C midhold k+%0d", j), 32'(c_sw), (j == 4) ? 32'd3 : 32'd2);
        end
        cyc(1, 0, 1);
        chk("C reset under hold", 32'(c_sw), 32'd1);
        cyc(1, 0, 1);
        cyc(0, 0, 1);
        chk("C held through reset", 32'(c_sw), 32'd2);
        chk("C held through reset changed", 32'(c_chg), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            cyc(0, 0, 1);
            chk($sformatf("C resumed k+%0d", j), 32'(c_sw), (j == 4) ? 32'd3 : 32'd2);
        end
        cyc(0, 0, 0);
        check_models();

        // Random phase against the reference model.
        ru = 1'b0;
        rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) ru = ~ru;
            if ($urandom_range(0, 5) == 0) rd = ~rd;
            rr = ($urandom_range(0, 199) == 0);
            cyc(rr, ru, rd);
            check_models();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
